hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard and stall controller for the 5-stage RV32I core. Generates stall, flush and forwarding controls for the F/D, D/E, E/M and M/W pipeline registers; resolves load-use and taken-branch hazards; freezes the pipeline while data memory is busy. A memory-wait watchdog and saturating stall/flush counters provide debug visibility.

## Interface
Parameters:
- `CNT_WIDTH`, 32: width of the performance counters.
- `MEM_TIMEOUT`, 16: consecutive memory-busy cycles before the error state; legal range 1..255.

Ports:
- `clk`  in  1  clock; rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `Rs1D`, `Rs2D`  in  5  source registers in Decode.
- `Rs1E`, `Rs2E`, `RdE`  in  5  sources and destination in Execute.
- `MemReadE`  in  1  load in Execute.
- `PCSrcE`  in  1  taken branch or jump resolved in Execute.
- `RdM`, `RdW`  in  5  destinations in Memory and Writeback.
- `RegWriteM`, `RegWriteW`  in  1  register write enables in Memory and Writeback.
- `MemAccessM`  in  1  load or store in Memory.
- `DMemReadyM`  in  1  data memory completes the access this cycle.
- `StallF`, `StallD`, `StallE`, `StallM`  out  1  hold PC, F/D, D/E and E/M registers.
- `FlushD`, `FlushE`, `FlushW`  out  1  bubble into F/D, D/E and M/W.
- `ForwardAE`, `ForwardBE`  out  2  ALU operand select: 00 register file, 01 Writeback result, 10 Memory ALU result.
- `MemTimeout`  out  1  sticky watchdog error.
- `StallCount`, `FlushCount`  out  CNT_WIDTH  saturating counters.

## Operation
- Forwarding, for operand A (B is identical using `Rs2E`):
  - `10` if `RegWriteM && RdM!=0 && RdM==Rs1E`.
  - Otherwise `01` if `RegWriteW && RdW!=0 && RdW==Rs1E`.
  - Otherwise `00`. Memory wins when both stages match.
- `memBusy = MemAccessM && !DMemReadyM`.
- `lwStall = MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D) && !PCSrcE`. A taken branch suppresses the load-use stall.
- State machine `RUN` / `MEM_WAIT` / `ERROR`:
  - `RUN` to `MEM_WAIT` when `memBusy`.
  - `MEM_WAIT` to `RUN` when `DMemReadyM`.
  - `MEM_WAIT` to `ERROR` when the wait counter reaches `MEM_TIMEOUT` with `memBusy` still true.
  - `ERROR` is left only by reset.
  - The wait counter is 8 bits. It counts consecutive `memBusy` cycles, including the entry cycle, and clears in `RUN`.
- Freeze, `frz = memBusy || state==ERROR`:
  - `StallF`, `StallD`, `StallE`, `StallM` = 1 and `FlushW` = 1.
  - `FlushD` = `FlushE` = 0.
  - A `PCSrcE` held during a freeze is applied on the first unfrozen cycle, because the Execute stage is held.
- When not frozen:
  - `StallF` = `StallD` = `lwStall`; `StallE` = `StallM` = `FlushW` = 0.
  - `FlushD` = `PCSrcE`; `FlushE` = `PCSrcE || lwStall`.
- `MemTimeout` = 1 while in `ERROR`.
- Counters saturate at all-ones:
  - `StallCount` increments on each cycle with any stall output high.
  - `FlushCount` increments on each cycle with `FlushD` high.

## Timing
- Stall, flush and forward outputs are combinational from the current-cycle inputs and the registered state. They are valid in the same cycle, before the edge that captures the pipeline registers.
- State, wait counter, `MemTimeout` and both counters are registered. They update on the rising edge of `clk`.
- Reset (`rst_n` low, asynchronous): state `RUN`, wait counter 0, `MemTimeout` 0, `StallCount` 0, `FlushCount` 0. With all inputs 0, every output is 0.
- Reset mid-wait or in `ERROR` returns the block to `RUN` immediately.
- With `MEM_TIMEOUT` = N, N consecutive `memBusy` cycles cause `ERROR` on the next edge. If ready arrives in cycle N, the block returns to `RUN` and does not enter `ERROR`.
- A load-use stall lasts exactly one cycle: after the edge, the load is in Memory and forwarding covers the dependency.

## Structure
- Package `hazard_pkg` holds:
  - `typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} hz_state_t`.
  - Forward encodings `FWD_RF=2'b00`, `FWD_WB=2'b01`, `FWD_MEM=2'b10`.
- Sub-module `forward_unit`: combinational; inputs one source register, `RdM`/`RegWriteM`, `RdW`/`RegWriteW`; output a 2-bit select. Instantiated twice, once for A and once for B.
- The state machine, watchdog and counters live in `hazard_controller`.

## Test plan
- Forwarding:
  - `Rs1E=5`, `RdM=5`, `RegWriteM=1`, `RdW=5`, `RegWriteW=1` gives `ForwardAE=10`.
  - With `RdM=0`, it gives `01`.
  - `Rs2E=0` with every match gives `ForwardBE=00`.
- Load-use: `MemReadE=1`, `RdE=3`, `Rs2D=3` gives `StallF=StallD=FlushE=1` for one cycle; `StallCount` becomes 1.
- Branch versus load-use: the same stimulus plus `PCSrcE=1` gives `StallF=0`, `FlushD=FlushE=1`; `FlushCount` becomes 1.
- Memory wait:
  - `MemAccessM=1`, `DMemReadyM=0` for 3 cycles, then 1, gives all stalls plus `FlushW` for 3 cycles, then `RUN`.
  - A `PCSrcE=1` held across the wait gives a flush only on the release cycle.
- Watchdog:
  - With `MEM_TIMEOUT=4` and busy held for 4 cycles, `MemTimeout=1` from the next cycle and stalls are held with ready=1.
  - Asserting `rst_n` low mid-error clears everything asynchronously.
- Saturation: preload `StallCount` to all-ones via hierarchical force; a further stall keeps it at all-ones.

Source files
------------

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the RV32I pipeline hazard controller.
//   hz_state_t : memory-wait state machine encoding (RUN / MEM_WAIT / ERROR)
//   FWD_*      : ALU operand forwarding select encodings
//   WAIT_W     : width of the memory-wait watchdog counter
//   reg_match  : "a writing stage produces the register this source reads"
// -----------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } hz_state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;   // register file value
   localparam logic [1:0] FWD_WB  = 2'b01;   // Writeback result
   localparam logic [1:0] FWD_MEM = 2'b10;   // Memory-stage ALU result

   localparam int WAIT_W = 8;

   // x0 is hard-wired to zero, so a write to it never produces a value worth
   // forwarding and never creates a dependency.
   function automatic logic reg_match(input logic       wr_en,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs);
      return wr_en && (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit
// Combinational forwarding select for one ALU source operand in Execute.
// Ports:
//   rs          in  5  source register of the operand in Execute
//   rd_m        in  5  destination register in Memory
//   reg_write_m in  1  Memory stage writes the register file
//   rd_w        in  5  destination register in Writeback
//   reg_write_w in  1  Writeback stage writes the register file
//   fwd_sel     out 2  FWD_MEM / FWD_WB / FWD_RF
// -----------------------------------------------------------------------------
module forward_unit
   import hazard_pkg::*;
(
   input  logic [4:0] rs,
   input  logic [4:0] rd_m,
   input  logic       reg_write_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_w,
   output logic [1:0] fwd_sel
);

   always_comb begin
      fwd_sel = FWD_RF;
      // Memory holds the younger instruction, so it wins over Writeback.
      if (reg_match(reg_write_m, rd_m, rs)) begin
         fwd_sel = FWD_MEM;
      end else if (reg_match(reg_write_w, rd_w, rs)) begin
         fwd_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
// Stall / flush / forwarding control for the 5-stage RV32I pipeline, with a
// memory-wait watchdog and saturating stall and flush counters.
// Ports:
//   clk, rst_n                        clock (rising edge), async active-low reset
//   Rs1D, Rs2D                  in  5 Decode source registers
//   Rs1E, Rs2E, RdE             in  5 Execute sources / destination
//   MemReadE                    in  1 load in Execute
//   PCSrcE                      in  1 taken branch / jump resolved in Execute
//   RdM, RdW                    in  5 Memory / Writeback destinations
//   RegWriteM, RegWriteW        in  1 Memory / Writeback write enables
//   MemAccessM                  in  1 load or store in Memory
//   DMemReadyM                  in  1 data memory completes this cycle
//   StallF/D/E/M                out 1 hold PC, F/D, D/E, E/M
//   FlushD/E/W                  out 1 bubble into F/D, D/E, M/W
//   ForwardAE, ForwardBE        out 2 ALU operand selects
//   MemTimeout                  out 1 sticky watchdog error
//   StallCount, FlushCount      out CNT_WIDTH saturating counters
// -----------------------------------------------------------------------------
module hazard_controller
   import hazard_pkg::*;
#(
   parameter int unsigned CNT_WIDTH   = 32,
   parameter int unsigned MEM_TIMEOUT = 16   // legal range 1..255
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [4:0]           Rs1D,
   input  logic [4:0]           Rs2D,
   input  logic [4:0]           Rs1E,
   input  logic [4:0]           Rs2E,
   input  logic [4:0]           RdE,
   input  logic                 MemReadE,
   input  logic                 PCSrcE,
   input  logic [4:0]           RdM,
   input  logic [4:0]           RdW,
   input  logic                 RegWriteM,
   input  logic                 RegWriteW,
   input  logic                 MemAccessM,
   input  logic                 DMemReadyM,
   output logic                 StallF,
   output logic                 StallD,
   output logic                 StallE,
   output logic                 StallM,
   output logic                 FlushD,
   output logic                 FlushE,
   output logic                 FlushW,
   output logic [1:0]           ForwardAE,
   output logic [1:0]           ForwardBE,
   output logic                 MemTimeout,
   output logic [CNT_WIDTH-1:0] StallCount,
   output logic [CNT_WIDTH-1:0] FlushCount
);

   localparam logic [WAIT_W-1:0]    TIMEOUT_VAL = MEM_TIMEOUT[WAIT_W-1:0];
   localparam logic [WAIT_W-1:0]    WAIT_ONE    = {{(WAIT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};

   // ------------------------------------------------------------------
   // Forwarding: one forward_unit per ALU operand
   // ------------------------------------------------------------------
   logic [4:0] rs_e    [2];
   logic [1:0] fwd_sel [2];

   assign rs_e[0] = Rs1E;
   assign rs_e[1] = Rs2E;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         forward_unit u_fwd (
            .rs          (rs_e[gi]),
            .rd_m        (RdM),
            .reg_write_m (RegWriteM),
            .rd_w        (RdW),
            .reg_write_w (RegWriteW),
            .fwd_sel     (fwd_sel[gi])
         );
      end
   endgenerate

   assign ForwardAE = fwd_sel[0];
   assign ForwardBE = fwd_sel[1];

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   hz_state_t             state_q,       state_d;
   logic [WAIT_W-1:0]     wait_cnt_q,    wait_cnt_d;
   logic                  mem_timeout_q, mem_timeout_d;
   logic [CNT_WIDTH-1:0]  stall_cnt_q,   stall_cnt_d;
   logic [CNT_WIDTH-1:0]  flush_cnt_q,   flush_cnt_d;

   // ------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------
   logic              mem_busy;
   logic              lw_stall;
   logic              frz;
   logic [WAIT_W-1:0] wait_inc;

   always_comb begin
      mem_busy = MemAccessM && !DMemReadyM;
      // A taken branch squashes the dependent Decode instruction anyway, so
      // stalling for it would only waste a cycle.
      lw_stall = MemReadE && (RdE != 5'd0) &&
                 ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;
      frz      = mem_busy || (state_q == ERROR);
      // Saturate so a very long wait can never wrap back below the limit.
      wait_inc = (wait_cnt_q == {WAIT_W{1'b1}}) ? wait_cnt_q
                                                : wait_cnt_q + WAIT_ONE;
   end

   // ------------------------------------------------------------------
   // Pipeline control outputs
   // ------------------------------------------------------------------
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (frz) begin
         // Whole front of the pipe holds; a bubble drains out of Memory.
         // FlushD/FlushE stay low so a branch resolved in the held Execute
         // stage is still there and acts on the first unfrozen cycle.
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else begin
         StallF = lw_stall;
         StallD = lw_stall;
         FlushD = PCSrcE;
         FlushE = PCSrcE || lw_stall;
      end
   end

   // ------------------------------------------------------------------
   // Memory-wait state machine and watchdog
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         RUN: begin
            wait_cnt_d = '0;
            if (mem_busy) begin
               // The entry cycle is already one busy cycle; with a limit
               // of 1 it alone is enough to trip the watchdog.
               wait_cnt_d = wait_inc;
               state_d    = (wait_inc >= TIMEOUT_VAL) ? ERROR : MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (DMemReadyM) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (mem_busy) begin
               wait_cnt_d = wait_inc;
               if (wait_inc >= TIMEOUT_VAL) begin
                  state_d = ERROR;
               end
            end else begin
               // Access withdrawn without completing: the busy run is
               // broken, so restart the count.
               wait_cnt_d = '0;
            end
         end
         ERROR: begin
            // Sticky until reset.
            state_d = ERROR;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
      mem_timeout_d = (state_d == ERROR);
   end

   // ------------------------------------------------------------------
   // Saturating debug counters
   // ------------------------------------------------------------------
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if ((StallF || StallD || StallE || StallM) && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (FlushD && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

   assign MemTimeout = mem_timeout_q;
   assign StallCount = stall_cnt_q;
   assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
// Directed and randomized checks of hazard_controller against a behavioural
// model built from the hazard rules (busy-run length, error flag, counters).
// -----------------------------------------------------------------------------
module tb_hazard_controller;

   localparam int CW  = 32;
   localparam int TMO = 4;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic          MemReadE, PCSrcE, RegWriteM, RegWriteW, MemAccessM, DMemReadyM;
   logic          StallF, StallD, StallE, StallM;
   logic          FlushD, FlushE, FlushW;
   logic [1:0]    ForwardAE, ForwardBE;
   logic          MemTimeout;
   logic [CW-1:0] StallCount, FlushCount;

   hazard_controller #(.CNT_WIDTH(CW), .MEM_TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Rs1D       (Rs1D),
      .Rs2D       (Rs2D),
      .Rs1E       (Rs1E),
      .Rs2E       (Rs2E),
      .RdE        (RdE),
      .MemReadE   (MemReadE),
      .PCSrcE     (PCSrcE),
      .RdM        (RdM),
      .RdW        (RdW),
      .RegWriteM  (RegWriteM),
      .RegWriteW  (RegWriteW),
      .MemAccessM (MemAccessM),
      .DMemReadyM (DMemReadyM),
      .StallF     (StallF),
      .StallD     (StallD),
      .StallE     (StallE),
      .StallM     (StallM),
      .FlushD     (FlushD),
      .FlushE     (FlushE),
      .FlushW     (FlushW),
      .ForwardAE  (ForwardAE),
      .ForwardBE  (ForwardBE),
      .MemTimeout (MemTimeout),
      .StallCount (StallCount),
      .FlushCount (FlushCount)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Behavioural model: length of the current busy run, sticky error flag,
   // and the two counters.
   int            streak;
   bit            err;
   logic [CW-1:0] m_stall, m_flush;
   logic [3:0]    e_st;   // {F, D, E, M}
   logic [2:0]    e_fl;   // {D, E, W}

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic compute_expect();
      bit busy, lw;
      busy = MemAccessM && !DMemReadyM;
      lw   = MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D) && !PCSrcE;
      if (busy || err) begin
         e_st = 4'b1111;
         e_fl = 3'b001;
      end else begin
         e_st = {lw, lw, 2'b00};
         e_fl = {PCSrcE, PCSrcE || lw, 1'b0};
      end
   endtask

   task automatic check_outputs();
      chk("ForwardAE",  64'(ForwardAE), 64'(ref_fwd(Rs1E)));
      chk("ForwardBE",  64'(ForwardBE), 64'(ref_fwd(Rs2E)));
      chk("Stalls",     64'({StallF, StallD, StallE, StallM}), 64'(e_st));
      chk("Flushes",    64'({FlushD, FlushE, FlushW}), 64'(e_fl));
      chk("MemTimeout", 64'(MemTimeout), 64'(err));
      chk("StallCount", 64'(StallCount), 64'(m_stall));
      chk("FlushCount", 64'(FlushCount), 64'(m_flush));
   endtask

   task automatic clear_inputs();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      MemReadE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
      MemAccessM = 0; DMemReadyM = 0;
   endtask

   // One clock cycle: check combinational and registered outputs mid-cycle,
   // advance the model for the coming edge, then step past the edge.
   task automatic cycle(input string name);
      bit busy;
      @(negedge clk);
      compute_expect();
      check_outputs();
      $display("cycle %-9s st=%b fl=%b fa=%b fb=%b to=%b sc=%0d fc=%0d",
               name, e_st, e_fl, ForwardAE, ForwardBE, MemTimeout, StallCount, FlushCount);
      busy = MemAccessM && !DMemReadyM;
      if (e_st != 4'b0000 && m_stall != '1) m_stall++;
      if (e_fl[2] && m_flush != '1) m_flush++;
      if (!err) begin
         streak = busy ? streak + 1 : 0;
         if (streak >= TMO) err = 1;
      end
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear at once.
   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      #2;
      chk("rst_MemTimeout", 64'(MemTimeout), 64'(0));
      chk("rst_StallCount", 64'(StallCount), 64'(0));
      chk("rst_FlushCount", 64'(FlushCount), 64'(0));
      chk("rst_Stalls",  64'({StallF, StallD, StallE, StallM}), 64'(0));
      chk("rst_Flushes", 64'({FlushD, FlushE, FlushW}), 64'(0));
      chk("rst_Fwd",     64'({ForwardAE, ForwardBE}), 64'(0));
      streak = 0; err = 0; m_stall = '0; m_flush = '0;
      $display("reset at %0t", $time);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      clear_inputs();
      streak = 0; err = 0; m_stall = '0; m_flush = '0;
      #1;
      do_reset();
      cycle("idle");

      // Forwarding priority and x0 handling
      Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs2E = 0;
      #1;
      chk("fwd_mem_wins", 64'(ForwardAE), 64'(2'b10));
      chk("fwd_x0",       64'(ForwardBE), 64'(2'b00));
      cycle("fwd_mem");
      RdM = 0;
      #1;
      chk("fwd_wb", 64'(ForwardAE), 64'(2'b01));
      cycle("fwd_wb");

      // Load-use stall
      clear_inputs();
      MemReadE = 1; RdE = 3; Rs2D = 3;
      #1;
      chk("lw_stall", 64'({StallF, StallD, FlushE}), 64'(3'b111));
      cycle("load_use");
      clear_inputs();
      chk("lw_count", 64'(StallCount), 64'(1));
      cycle("after_lw");

      // Branch suppresses load-use
      MemReadE = 1; RdE = 3; Rs2D = 3; PCSrcE = 1;
      #1;
      chk("br_vs_lw", 64'({StallF, FlushD, FlushE}), 64'(3'b011));
      cycle("branch");
      clear_inputs();
      chk("br_count", 64'(FlushCount), 64'(1));

      // Memory wait: 3 busy cycles then ready
      MemAccessM = 1;
      for (int i = 0; i < 3; i++) cycle("mem_busy");
      DMemReadyM = 1;
      #1;
      chk("mem_release", 64'({StallF, StallM, FlushW}), 64'(0));
      cycle("mem_done");

      // Branch held across a wait acts only on release
      DMemReadyM = 0; PCSrcE = 1;
      #1;
      chk("br_frozen", 64'(FlushD), 64'(0));
      cycle("br_wait");
      cycle("br_wait");
      DMemReadyM = 1;
      #1;
      chk("br_release", 64'({FlushD, FlushE}), 64'(2'b11));
      cycle("br_rel");
      clear_inputs();

      // Watchdog: TMO busy cycles trip the error, ready no longer releases
      MemAccessM = 1;
      for (int i = 0; i < TMO; i++) cycle("wd_busy");
      DMemReadyM = 1;
      #1;
      chk("wd_error", 64'(MemTimeout), 64'(1));
      chk("wd_held",  64'(StallF), 64'(1));
      cycle("wd_err");
      cycle("wd_err");
      do_reset();
      cycle("post_rst");

      // Stall counter saturation
      @(negedge clk);
      force dut.stall_cnt_q = '1;
      #1;
      release dut.stall_cnt_q;
      m_stall = '1;
      @(posedge clk);
      #1;
      MemReadE = 1; RdE = 7; Rs1D = 7;
      cycle("sat");
      clear_inputs();
      chk("sat_hold", 64'(StallCount), 64'({CW{1'b1}}));
      cycle("sat_idle");
      do_reset();

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         if ((err && $urandom_range(0, 3) == 0) || $urandom_range(0, 40) == 0) begin
            do_reset();
         end else begin
            Rs1D = 5'($urandom_range(0, 3));  Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3));  Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3));  RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            MemReadE   = 1'($urandom_range(0, 1));
            PCSrcE     = ($urandom_range(0, 3) == 0);
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            MemAccessM = ($urandom_range(0, 2) == 0) || (streak > 0);
            DMemReadyM = ($urandom_range(0, 2) == 0);
            cycle("rand");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
